// File: rtl/imem_arbiter.sv
// Round-robin arbiter sharing the instruction memory read port between fetch and debug,
// with a MEM_LAT-deep response tracker that routes each returned word to its requester.
module imem_arbiter #(
   parameter int unsigned ADDR_W  = 64,
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned MEM_LAT = 1
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              fetch_req,
   input  logic [ADDR_W-1:0] fetch_addr,
   output logic              fetch_gnt,
   output logic              fetch_rvalid,
   output logic              fetch_err,
   input  logic              dbg_req,
   input  logic [ADDR_W-1:0] dbg_addr,
   output logic              dbg_gnt,
   output logic              dbg_rvalid,
   output logic              dbg_err,
   output logic [DATA_W-1:0] rdata,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_rdata
);

   typedef enum logic {OWN_FETCH = 1'b0, OWN_DBG = 1'b1} owner_e;

   typedef struct packed {
      logic   valid;
      owner_e owner;
      logic   misaligned;
   } resp_t;

   owner_e            last_owner_q, last_owner_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [ADDR_W-1:0] sel_addr;
   logic              grant_fetch, grant_dbg, granted;
   resp_t             stage_in, pipe_out;
   resp_t             pipe_q [MEM_LAT];

   // State: arbitration history, held memory address and response shift register.
   always_ff @(posedge clk or posedge resetn) begin
      if (resetn) begin
         last_owner_q <= OWN_DBG;
         mem_addr_q   <= '0;
         for (int unsigned i = 0; i < MEM_LAT; i++) pipe_q[i] <= '0;
      end else begin
         last_owner_q <= last_owner_d;
         mem_addr_q   <= mem_addr_d;
         pipe_q[0]    <= stage_in;
         for (int unsigned i = 1; i < MEM_LAT; i++) pipe_q[i] <= pipe_q[i-1];
      end
   end

   // Zero-latency grant; on a tie the requester not granted last wins.
   always_comb begin
      grant_fetch  = 1'b0;
      grant_dbg    = 1'b0;
      last_owner_d = last_owner_q;
      if (!resetn) begin
         if (fetch_req && dbg_req) begin
            grant_fetch = (last_owner_q == OWN_DBG);
            grant_dbg   = (last_owner_q == OWN_FETCH);
         end else begin
            grant_fetch = fetch_req;
            grant_dbg   = dbg_req;
         end
         if (grant_fetch)    last_owner_d = OWN_FETCH;
         else if (grant_dbg) last_owner_d = OWN_DBG;
      end
      granted    = grant_fetch || grant_dbg;
      sel_addr   = grant_dbg ? dbg_addr : fetch_addr;
      mem_addr_d = granted ? {sel_addr[ADDR_W-1:2], 2'b00} : mem_addr_q;
      stage_in.valid      = granted;
      stage_in.owner      = grant_dbg ? OWN_DBG : OWN_FETCH;
      stage_in.misaligned = granted && (sel_addr[1:0] != 2'b00);
   end

   assign pipe_out     = pipe_q[MEM_LAT-1];
   assign fetch_gnt    = grant_fetch;
   assign dbg_gnt      = grant_dbg;
   assign mem_addr     = resetn ? '0 : mem_addr_d;
   assign fetch_rvalid = pipe_out.valid && (pipe_out.owner == OWN_FETCH);
   assign dbg_rvalid   = pipe_out.valid && (pipe_out.owner == OWN_DBG);
   assign fetch_err    = fetch_rvalid && pipe_out.misaligned;
   assign dbg_err      = dbg_rvalid && pipe_out.misaligned;
   // Misaligned reads return zero instead of the memory word.
   assign rdata        = (pipe_out.valid && !pipe_out.misaligned) ? mem_rdata : '0;

endmodule

// File: tb/tb_imem_arbiter.sv
// Drives three arbiters (MEM_LAT 1..3) with shared stimulus and checks each against
// a cycle-scheduled reference model of grants and responses.
module tb_imem_arbiter;
   localparam int unsigned NINST = 3;
   localparam int unsigned NC    = 2048;

   logic        clk = 1'b0;
   logic        resetn;
   logic        fetch_req, dbg_req;
   logic [63:0] fetch_addr, dbg_addr;

   logic        fg [NINST], dg [NINST], fv [NINST], dv [NINST], fe [NINST], de [NINST];
   logic [31:0] rd [NINST], mrd [NINST];
   logic [63:0] ma [NINST];

   always #5 clk = ~clk;

   function automatic logic [31:0] memf(input logic [63:0] a);
      return a[31:0] ^ a[63:32] ^ 32'h5A5A_1234;
   endfunction

   for (genvar k = 0; k < NINST; k++) begin : g_dut
      localparam int unsigned LAT = k + 1;
      logic [63:0] hist [4];
      imem_arbiter #(.ADDR_W(64), .DATA_W(32), .MEM_LAT(LAT)) u_dut (
         .clk(clk), .resetn(resetn),
         .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_gnt(fg[k]),
         .fetch_rvalid(fv[k]), .fetch_err(fe[k]),
         .dbg_req(dbg_req), .dbg_addr(dbg_addr), .dbg_gnt(dg[k]),
         .dbg_rvalid(dv[k]), .dbg_err(de[k]),
         .rdata(rd[k]), .mem_addr(ma[k]), .mem_rdata(mrd[k]));
      // Memory model: word for the address driven LAT cycles earlier.
      always @(posedge clk) begin
         hist[0] <= ma[k];
         for (int i = 1; i < 4; i++) hist[i] <= hist[i-1];
      end
      assign mrd[k] = memf(hist[LAT-1]);
   end

   int n_checks = 0;
   int n_errors = 0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Reference model: responses scheduled by the cycle they are due in.
   logic        exp_v   [NINST][NC];
   logic        exp_own [NINST][NC];
   logic        exp_err [NINST][NC];
   logic [63:0] exp_adr [NINST][NC];
   logic        m_last;
   logic [63:0] m_addr;
   logic        last_gf, last_gd;
   int          cyc = 0;

   task automatic step();
      logic gf, gd, ev, eo, ee;
      logic [63:0] sa, mexp, edata;
      @(negedge clk);
      gf = 1'b0;
      gd = 1'b0;
      if (resetn) begin
         for (int k = 0; k < NINST; k++)
            for (int c = cyc; c < NC; c++) exp_v[k][c] = 1'b0;
         m_last = 1'b1;
         m_addr = '0;
      end else if (fetch_req && dbg_req) begin
         gf = m_last;
         gd = !m_last;
      end else begin
         gf = fetch_req;
         gd = dbg_req;
      end
      sa   = gd ? dbg_addr : fetch_addr;
      mexp = (gf || gd) ? {sa[63:2], 2'b00} : m_addr;
      for (int k = 0; k < NINST; k++) begin
         ev = exp_v[k][cyc];
         eo = exp_own[k][cyc];
         ee = exp_err[k][cyc];
         edata = (ev && !ee) ? 64'(memf(exp_adr[k][cyc])) : 64'd0;
         check_eq($sformatf("fetch_gnt L%0d c%0d", k+1, cyc), 64'(fg[k]), 64'(gf));
         check_eq($sformatf("dbg_gnt L%0d c%0d", k+1, cyc), 64'(dg[k]), 64'(gd));
         check_eq($sformatf("mem_addr L%0d c%0d", k+1, cyc), ma[k], mexp);
         check_eq($sformatf("fetch_rvalid L%0d c%0d", k+1, cyc), 64'(fv[k]), 64'(ev && !eo));
         check_eq($sformatf("dbg_rvalid L%0d c%0d", k+1, cyc), 64'(dv[k]), 64'(ev && eo));
         check_eq($sformatf("rdata L%0d c%0d", k+1, cyc), 64'(rd[k]), edata);
         if (ev && !eo) check_eq($sformatf("fetch_err L%0d c%0d", k+1, cyc), 64'(fe[k]), 64'(ee));
         if (ev && eo)  check_eq($sformatf("dbg_err L%0d c%0d", k+1, cyc), 64'(de[k]), 64'(ee));
         if (resetn) begin
            check_eq($sformatf("rst fetch_err L%0d c%0d", k+1, cyc), 64'(fe[k]), 64'd0);
            check_eq($sformatf("rst dbg_err L%0d c%0d", k+1, cyc), 64'(de[k]), 64'd0);
         end
         if ((gf || gd) && (cyc + k + 1 < NC)) begin
            exp_v[k][cyc+k+1]   = 1'b1;
            exp_own[k][cyc+k+1] = gd;
            exp_err[k][cyc+k+1] = (sa[1:0] != 2'b00);
            exp_adr[k][cyc+k+1] = mexp;
         end
      end
      if (gf || gd) m_last = gd;
      m_addr  = mexp;
      last_gf = gf;
      last_gd = gd;
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic drive(input logic fr, input logic [63:0] fa, input logic dr,
                        input logic [63:0] da, input logic rst);
      fetch_req  = fr;
      fetch_addr = fa;
      dbg_req    = dr;
      dbg_addr   = da;
      resetn     = rst;
      step();
   endtask

   function automatic logic [63:0] raddr();
      logic [63:0] a;
      a = {32'($urandom), 32'($urandom)};
      if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      return a;
   endfunction

   initial begin
      for (int k = 0; k < NINST; k++)
         for (int c = 0; c < NC; c++) begin
            exp_v[k][c] = 1'b0; exp_own[k][c] = 1'b0; exp_err[k][c] = 1'b0; exp_adr[k][c] = '0;
         end
      m_last = 1'b1; m_addr = '0; last_gf = 1'b0; last_gd = 1'b0;
      fetch_req = 1'b1; fetch_addr = 64'h44; dbg_req = 1'b1; dbg_addr = 64'h88; resetn = 1'b1;
      #1;
      step();
      drive(1'b0, 64'h0, 1'b0, 64'h0, 1'b1);
      // Fetch streak, then tie for four cycles, then a misaligned debug read.
      drive(1'b1, 64'h0, 1'b0, 64'h0, 1'b0);
      drive(1'b1, 64'h4, 1'b0, 64'h0, 1'b0);
      drive(1'b1, 64'h8, 1'b0, 64'h0, 1'b0);
      drive(1'b0, 64'h8, 1'b0, 64'h0, 1'b0);
      drive(1'b1, 64'h10, 1'b1, 64'h20, 1'b1);
      for (int i = 0; i < 4; i++) drive(1'b1, 64'h10 + 64'(4*i), 1'b1, 64'h20 + 64'(4*i), 1'b0);
      for (int i = 0; i < 3; i++) drive(1'b0, 64'h0, 1'b0, 64'h0, 1'b0);
      drive(1'b0, 64'h0, 1'b1, 64'h102, 1'b0);
      for (int i = 0; i < 3; i++) drive(1'b0, 64'h0, 1'b0, 64'h0, 1'b0);
      drive(1'b1, 64'h40, 1'b0, 64'h0, 1'b0);
      for (int i = 0; i < 4; i++) drive(1'b0, 64'h0, 1'b0, 64'h0, 1'b0);
      // Three grants and a gap, then reset right behind an in-flight grant.
      for (int i = 0; i < 3; i++) drive(1'b1, 64'(4*i), 1'b0, 64'h0, 1'b0);
      for (int i = 0; i < 4; i++) drive(1'b0, 64'h0, 1'b0, 64'h0, 1'b0);
      drive(1'b1, 64'h80, 1'b0, 64'h0, 1'b0);
      drive(1'b1, 64'h84, 1'b1, 64'h90, 1'b1);
      drive(1'b1, 64'h84, 1'b1, 64'h90, 1'b0);
      drive(1'b1, 64'h88, 1'b1, 64'h90, 1'b0);
      for (int i = 0; i < 4; i++) drive(1'b0, 64'h0, 1'b0, 64'h0, 1'b0);
      // Random traffic obeying the hold-until-granted rule, with rare resets.
      fetch_req = 1'b0;
      dbg_req   = 1'b0;
      while (cyc < 1500) begin
         if (!fetch_req || last_gf) begin
            fetch_req  = ($urandom_range(0, 3) != 0);
            fetch_addr = raddr();
         end
         if (!dbg_req || last_gd) begin
            dbg_req  = ($urandom_range(0, 1) != 0);
            dbg_addr = raddr();
         end
         resetn = ($urandom_range(0, 99) == 0);
         step();
      end
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
